// File: rtl/ddc_dec4.sv
// Receive downconverter: mixes 16 real lanes by a fixed fs/4-multiple tone and
// decimates by 4 through an 8-tap boxcar, giving 4 complex samples per clock.

module ddc_dec4_lane #(
    parameter int B  = 16,
    parameter int PH = 0
) (
    input  logic [1:0]   mode,
    input  logic [B-1:0] x,
    output logic [B-1:0] yi,
    output logic [B-1:0] yq
);
    localparam logic [1:0] PH2 = 2'(PH);
    localparam logic [B-1:0] MIN_V = {1'b1, {(B-1){1'b0}}};
    localparam logic [B-1:0] MAX_V = {1'b0, {(B-1){1'b1}}};

    logic [B-1:0] neg;
    logic [1:0]   rot;

    assign neg = (x == MIN_V) ? MAX_V : (~x + B'(1));

    // rot is the power of j this lane is multiplied by
    always_comb begin
        case (mode)
            2'd0:    rot = 2'd0;
            2'd1:    rot = 2'd0 - PH2;
            2'd2:    rot = {PH2[0], 1'b0};
            default: rot = PH2;
        endcase
    end

    always_comb begin
        yi = '0;
        yq = '0;
        case (rot)
            2'd0:    yi = x;
            2'd1:    yq = x;
            2'd2:    yi = neg;
            default: yq = neg;
        endcase
    end
endmodule

module ddc_dec4 #(
    parameter int B = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [16*B-1:0] din,
    input  logic            din_valid,
    output logic [8*B-1:0]  dout,
    output logic            dout_valid,
    input  logic [1:0]      MODE_REG
);
    localparam int NUM_LANES = 16;
    localparam int NUM_OUT   = 4;
    localparam int SW        = B + 3;

    logic [NUM_LANES-1:0][B-1:0] mix_i, mix_q;
    logic [NUM_LANES-1:0][B-1:0] s1_i_q, s1_i_d, s1_q_q, s1_q_d;
    logic [3:0][B-1:0]           hist_i_q, hist_i_d, hist_q_q, hist_q_d;
    logic [NUM_LANES+3:0][B-1:0] ext_i, ext_q;
    logic [NUM_OUT-1:0][SW-1:0]  sum_i_q, sum_i_d, sum_q_q, sum_q_d;
    logic [8*B-1:0]              dout_q, dout_d;
    logic                        dout_valid_q, dout_valid_d;
    logic [1:0]                  mode_q, mode_d;
    logic                        fresh_q, fresh_d;
    logic [2:1]                  vld_pipe_q, vld_pipe_d;
    logic [2:1]                  sup_pipe_q, sup_pipe_d;
    logic                        chg;

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        ddc_dec4_lane #(.B(B), .PH(n % 4)) u_lane (
            .mode (MODE_REG),
            .x    (din[B*n +: B]),
            .yi   (mix_i[n]),
            .yq   (mix_q[n])
        );
    end

    // Index m of ext is stream position m-4: history occupies the negative taps.
    assign ext_i = {s1_i_q, hist_i_q};
    assign ext_q = {s1_q_q, hist_q_q};

    function automatic logic [SW-1:0] sum8(input logic [7:0][B-1:0] v);
        logic [SW-1:0] acc;
        acc = '0;
        for (int j = 0; j < 8; j++) acc = acc + {{3{v[j][B-1]}}, v[j]};
        return acc;
    endfunction

    function automatic logic [B-1:0] rnd(input logic [SW-1:0] s);
        logic [SW:0] u, v;
        u = {s[SW-1], s} + (SW+1)'(4);
        v = {{3{u[SW]}}, u[SW:3]};
        if ((&v[SW:B-1]) || !(|v[SW:B-1])) return v[B-1:0];
        return v[SW] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
    endfunction

    // The first beat after reset already sees zero history, so it is not a mode change.
    assign chg = din_valid && !fresh_q && (MODE_REG != mode_q);

    always_comb begin
        mode_d       = mode_q;
        fresh_d      = fresh_q;
        s1_i_d       = s1_i_q;
        s1_q_d       = s1_q_q;
        hist_i_d     = hist_i_q;
        hist_q_d     = hist_q_q;
        sum_i_d      = sum_i_q;
        sum_q_d      = sum_q_q;
        dout_d       = dout_q;
        vld_pipe_d   = {vld_pipe_q[1], din_valid};
        sup_pipe_d   = {sup_pipe_q[1], chg};
        dout_valid_d = vld_pipe_q[2] && !sup_pipe_q[2];

        if (din_valid) begin
            mode_d  = MODE_REG;
            fresh_d = 1'b0;
            s1_i_d  = mix_i;
            s1_q_d  = mix_q;
            for (int l = 0; l < 4; l++) begin
                hist_i_d[l] = chg ? '0 : s1_i_q[12+l];
                hist_q_d[l] = chg ? '0 : s1_q_q[12+l];
            end
        end

        if (vld_pipe_q[1]) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                sum_i_d[k] = sum8(ext_i[4*k +: 8]);
                sum_q_d[k] = sum8(ext_q[4*k +: 8]);
            end
        end

        if (vld_pipe_q[2] && !sup_pipe_q[2]) begin
            for (int k = 0; k < NUM_OUT; k++)
                dout_d[2*B*k +: 2*B] = {rnd(sum_q_q[k]), rnd(sum_i_q[k])};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q       <= '0;
            fresh_q      <= 1'b1;
            s1_i_q       <= '0;
            s1_q_q       <= '0;
            hist_i_q     <= '0;
            hist_q_q     <= '0;
            sum_i_q      <= '0;
            sum_q_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            vld_pipe_q   <= '0;
            sup_pipe_q   <= '0;
        end else begin
            mode_q       <= mode_d;
            fresh_q      <= fresh_d;
            s1_i_q       <= s1_i_d;
            s1_q_q       <= s1_q_d;
            hist_i_q     <= hist_i_d;
            hist_q_q     <= hist_q_d;
            sum_i_q      <= sum_i_d;
            sum_q_q      <= sum_q_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            vld_pipe_q   <= vld_pipe_d;
            sup_pipe_q   <= sup_pipe_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_ddc_dec4.sv
// Directed bench for ddc_dec4: hand-computed output beats and arrival cycles.

module tb_ddc_dec4;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [255:0] din = '0;
    logic         din_valid = 1'b0;
    logic [127:0] dout;
    logic         dout_valid;
    logic [1:0]   mode = 2'd0;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [127:0] outq[$];
    int           outc[$];
    logic [127:0] expq[$];
    int           expc[$];

    ddc_dec4 #(.B(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .MODE_REG   (mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) begin
            outq.push_back(dout);
            outc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [127:0] pk(input int i0, input int i1, input int i2, input int i3, input int q);
        return {16'(q), 16'(i3), 16'(q), 16'(i2), 16'(q), 16'(i1), 16'(q), 16'(i0)};
    endfunction

    function automatic logic [255:0] pat(input int a0, input int a1, input int a2, input int a3);
        logic [255:0] r;
        for (int n = 0; n < 16; n++) begin
            case (n % 4)
                0:       r[16*n +: 16] = 16'(a0);
                1:       r[16*n +: 16] = 16'(a1);
                2:       r[16*n +: 16] = 16'(a2);
                default: r[16*n +: 16] = 16'(a3);
            endcase
        end
        return r;
    endfunction

    // One input cycle; a valid beat with ex=1 is expected at the output 3 clocks later.
    task automatic beat(input logic v, input logic [1:0] m, input int a0, input int a1,
                        input int a2, input int a3, input logic ex, input logic [127:0] ev);
        din = pat(a0, a1, a2, a3);
        din_valid = v;
        mode = m;
        @(posedge clk);
        #1;
        if (v && ex) begin
            expq.push_back(ev);
            expc.push_back(cyc + 2);
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic verify(input string tag);
        int n;
        check({tag, "_count"}, 128'(outq.size()), 128'(expq.size()));
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_val%0d", tag, i), outq[i], expq[i]);
            check($sformatf("%s_cyc%0d", tag, i), 128'(outc[i]), 128'(expc[i]));
        end
        outq.delete(); outc.delete(); expq.delete(); expc.delete();
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        outq.delete(); outc.delete(); expq.delete(); expc.delete();
    endtask

    initial begin
        logic [127:0] first1k, all1k, zero;
        first1k = pk(500, 1000, 1000, 1000, 0);
        all1k   = pk(1000, 1000, 1000, 1000, 0);
        zero    = pk(0, 0, 0, 0, 0);

        #2;
        check("rst_dout", dout, 128'(0));
        check("rst_valid", 128'(dout_valid), 128'(0));
        do_reset();

        // constant 1000, bypass
        beat(1, 0, 1000, 1000, 1000, 1000, 1, first1k);
        for (int i = 0; i < 4; i++) beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        idle(5);
        verify("m0");
        check("hold_dout", dout, all1k);
        check("hold_valid", 128'(dout_valid), 128'(0));

        // fs/2 mix of a constant cancels in the boxcar
        do_reset();
        for (int i = 0; i < 4; i++) beat(1, 2, 1000, 1000, 1000, 1000, 1, zero);
        idle(5);
        verify("m2");

        // -fs/4 tone at (1000,0,-1000,0) lands at DC
        do_reset();
        beat(1, 1, 1000, 0, -1000, 0, 1, pk(250, 500, 500, 500, 0));
        for (int i = 0; i < 3; i++) beat(1, 1, 1000, 0, -1000, 0, 1, pk(500, 500, 500, 500, 0));
        idle(5);
        verify("m1");

        // saturating negation of the most negative code
        do_reset();
        for (int i = 0; i < 4; i++) beat(1, 2, -32768, -32768, -32768, -32768, 1, zero);
        idle(5);
        verify("sat_m2");

        do_reset();
        beat(1, 0, -32768, -32768, -32768, -32768, 1, pk(-16384, -32768, -32768, -32768, 0));
        for (int i = 0; i < 3; i++)
            beat(1, 0, -32768, -32768, -32768, -32768, 1, pk(-32768, -32768, -32768, -32768, 0));
        idle(5);
        verify("sat_neg");

        do_reset();
        beat(1, 0, 32767, 32767, 32767, 32767, 1, pk(16384, 32767, 32767, 32767, 0));
        for (int i = 0; i < 3; i++)
            beat(1, 0, 32767, 32767, 32767, 32767, 1, pk(32767, 32767, 32767, 32767, 0));
        idle(5);
        verify("sat_pos");

        // two-cycle gap keeps history; cycles are checked via the scoreboard
        do_reset();
        beat(1, 0, 1000, 1000, 1000, 1000, 1, first1k);
        beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        beat(0, 0, 1000, 1000, 1000, 1000, 0, zero);
        beat(0, 2, 1000, 1000, 1000, 1000, 0, zero);
        for (int i = 0; i < 3; i++) beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        idle(5);
        verify("gap");

        // mode changes: each new-mode beat is dropped, including back-to-back ones
        do_reset();
        beat(1, 0, 1000, 1000, 1000, 1000, 1, first1k);
        beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        beat(1, 2, 1000, 1000, 1000, 1000, 0, zero);
        for (int i = 0; i < 3; i++) beat(1, 2, 1000, 1000, 1000, 1000, 1, zero);
        beat(1, 0, 1000, 1000, 1000, 1000, 0, zero);
        beat(1, 2, 1000, 1000, 1000, 1000, 0, zero);
        beat(1, 2, 1000, 1000, 1000, 1000, 1, zero);
        idle(5);
        verify("mchg");

        // reset with the pipeline full
        do_reset();
        beat(1, 0, 1000, 1000, 1000, 1000, 1, first1k);
        beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        for (int i = 0; i < 3; i++) beat(1, 0, 1000, 1000, 1000, 1000, 0, zero);
        rstn = 1'b0;
        #1;
        check("mid_rst_dout", dout, 128'(0));
        check("mid_rst_valid", 128'(dout_valid), 128'(0));
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        beat(1, 0, 1000, 1000, 1000, 1000, 1, first1k);
        beat(1, 0, 1000, 1000, 1000, 1000, 1, all1k);
        idle(5);
        verify("mid_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
